// File: rtl/walk_display_driver.sv
// Pedestrian signal display back end: row-scanned 8x8 figure (stand / two-frame walk)
// and a two-digit multiplexed seven-segment countdown, with blinking in the last seconds.
module walk_display_driver #(
   parameter int SCAN_DIV  = 1000,
   parameter int FRAME_DIV = 250,
   parameter int BLINK_DIV = 125
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pattern,
   input  logic [3:0] second,
   input  logic       pause,
   output logic [7:0] row_sel,
   output logic [7:0] col,
   output logic [6:0] seg,
   output logic [1:0] an
);
   localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int FW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   typedef enum logic [1:0] {STAND, WALK_A, WALK_B} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] presc_q, presc_d;
   logic [2:0]    row_idx_q, row_idx_d;
   logic          dig_idx_q, dig_idx_d;
   logic [FW-1:0] frame_cnt_q, frame_cnt_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_on_q, blink_on_d;
   logic [7:0]    row_sel_q, row_sel_d;
   logic [7:0]    col_q, col_d;
   logic [6:0]    seg_q, seg_d;
   logic [1:0]    an_q, an_d;
   logic          scan_tick;
   logic          blink_act;
   logic          show_dig;
   logic [3:0]    ones;

   function automatic logic [7:0] bitmap(input state_t s, input logic [2:0] r);
      logic [7:0] v;
      v = 8'h18;
      case (s)
         WALK_A: case (r)
            3'd2: v = 8'h3A;   3'd3: v = 8'h5C;   3'd4: v = 8'h18;
            3'd5: v = 8'h24;   3'd6: v = 8'h42;   3'd7: v = 8'h81;
            default: v = 8'h18;
         endcase
         WALK_B: case (r)
            3'd2: v = 8'h5C;   3'd3: v = 8'h3A;   3'd4: v = 8'h18;
            3'd5: v = 8'h28;   3'd6: v = 8'h24;   3'd7: v = 8'h24;
            default: v = 8'h18;
         endcase
         default: case (r)
            3'd2: v = 8'h3C;   3'd3: v = 8'h5A;   3'd4: v = 8'h18;
            3'd5: v = 8'h24;   3'd6: v = 8'h24;   3'd7: v = 8'h24;
            default: v = 8'h18;
         endcase
      endcase
      return v;
   endfunction

   // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 blanks the digit.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;   4'd1: return 7'h79;   4'd2: return 7'h24;
         4'd3: return 7'h30;   4'd4: return 7'h19;   4'd5: return 7'h12;
         4'd6: return 7'h02;   4'd7: return 7'h78;   4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h7F;
      endcase
   endfunction

   assign scan_tick = (presc_q == SCAN_LAST);
   assign blink_act = pattern && (second >= 4'd1) && (second <= 4'd3);
   assign ones      = (second == 4'd10) ? 4'd0 : second;

   always_ff @(posedge clk) begin
      if (rst) state_q <= STAND;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      if (!pattern) begin
         state_d     = STAND;
         frame_cnt_d = '0;
      end else if (state_q == STAND) begin
         state_d     = WALK_A;
         frame_cnt_d = '0;
      end else if (scan_tick && !pause) begin
         if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d = '0;
            state_d     = (state_q == WALK_A) ? WALK_B : WALK_A;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      presc_d     = scan_tick ? '0 : presc_q + 1'b1;
      row_idx_d   = scan_tick ? row_idx_q + 3'd1 : row_idx_q;
      dig_idx_d   = scan_tick ? ~dig_idx_q : dig_idx_q;
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;
      if (!blink_act) begin
         blink_cnt_d = '0;
         blink_on_d  = 1'b1;
      end else if (scan_tick && !pause) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   // Output stage renders the pre-update indices so a new row appears one clock after its tick.
   always_comb begin
      row_sel_d = 8'h01 << row_idx_q;
      an_d      = dig_idx_q ? 2'b01 : 2'b10;
      col_d     = blink_on_q ? bitmap(state_q, row_idx_q) : 8'h00;
      show_dig  = pattern && (second >= 4'd1) && (second <= 4'd10) && blink_on_q;
      seg_d     = 7'h7F;
      if (show_dig) begin
         if (!dig_idx_q)             seg_d = seg7(ones);
         else if (second == 4'd10)   seg_d = seg7(4'd1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q     <= '0;
         row_idx_q   <= '0;
         dig_idx_q   <= 1'b0;
         frame_cnt_q <= '0;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         row_sel_q   <= 8'h00;
         col_q       <= 8'h00;
         seg_q       <= 7'h7F;
         an_q        <= 2'b11;
      end else begin
         presc_q     <= presc_d;
         row_idx_q   <= row_idx_d;
         dig_idx_q   <= dig_idx_d;
         frame_cnt_q <= frame_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         row_sel_q   <= row_sel_d;
         col_q       <= col_d;
         seg_q       <= seg_d;
         an_q        <= an_d;
      end
   end

   assign row_sel = row_sel_q;
   assign col     = col_q;
   assign seg     = seg_q;
   assign an      = an_q;

endmodule
